// File: rtl/cmp_slice_pkg.sv
// Shared geometry, top-level state encoding and result-word field map for the
// compare-ALU slice interface.
package cmp_slice_pkg;

  localparam int unsigned BMP_ROWS  = 64;
  localparam int unsigned BMP_COLS  = 24;
  localparam int unsigned HALF_ROWS = 32;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    START    = 2'd1,
    STREAM   = 2'd2,
    WAITDONE = 2'd3
  } state_t;

  // Field positions inside the 16-bit shift/scale word returned by cmpalu.
  localparam int unsigned LSHIFT_LSB = 0;
  localparam int unsigned LSHIFT_MSB = 4;
  localparam int unsigned DSHIFT_LSB = 5;
  localparam int unsigned DSHIFT_MSB = 10;
  localparam int unsigned HSCALE_BIT = 11;
  localparam int unsigned VSCALE_BIT = 12;

endpackage

// File: rtl/slice_stream_ctl.sv
// One stream controller: walks an index from FIRST_IDX to LAST_IDX (up or down),
// presenting each index with a one-cycle strobe, then a blanking gap, then an ack wait.
module slice_stream_ctl #(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned FIRST_IDX = 0,
  parameter int unsigned LAST_IDX  = 31,
  parameter bit          DESCEND   = 1'b0,
  parameter int unsigned ACK_BLANK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             ack,
  output logic [IDX_W-1:0] idx,
  output logic             strobe,
  output logic             exhausted
);

  localparam int unsigned BL_W = (ACK_BLANK > 2) ? $clog2(ACK_BLANK) : 1;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_PRESENT = 3'd1,
    PH_BLANK   = 3'd2,
    PH_WAIT    = 3'd3,
    PH_DONE    = 3'd4
  } phase_t;

  phase_t          phase;
  logic [BL_W-1:0] blank_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PH_IDLE;
      idx       <= '0;
      blank_cnt <= '0;
    end else begin
      case (phase)
        PH_IDLE, PH_DONE: begin
          if (go) begin
            phase <= PH_PRESENT;
            idx   <= IDX_W'(FIRST_IDX);
          end
        end
        PH_PRESENT: begin
          blank_cnt <= '0;
          phase     <= (ACK_BLANK == 0) ? PH_WAIT : PH_BLANK;
        end
        PH_BLANK: begin
          if (blank_cnt == BL_W'(ACK_BLANK - 1)) begin
            phase <= PH_WAIT;
          end else begin
            blank_cnt <= blank_cnt + BL_W'(1);
          end
        end
        PH_WAIT: begin
          if (ack) begin
            if (idx == IDX_W'(LAST_IDX)) begin
              phase <= PH_DONE;
            end else begin
              idx   <= DESCEND ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
              phase <= PH_PRESENT;
            end
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

  assign strobe    = (phase == PH_PRESENT);
  assign exhausted = (phase == PH_DONE);

endmodule

// File: rtl/bitmap_slicer.sv
// Buffers a 64x24 bitmap and streams columns, top rows and bottom rows to cmpalu,
// then captures its result word. Optional watchdog: define BITMAP_SLICER_WDOG_EN.
module bitmap_slicer
  import cmp_slice_pkg::*;
#(
  parameter int unsigned ACK_BLANK = 1
`ifdef BITMAP_SLICER_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic        load_ready,
  output logic        start,
  output logic [63:0] bitcolumn,
  output logic [23:0] bitrowtop,
  output logic [23:0] bitrowbot,
  output logic        nextcolumnready,
  output logic        nextrowtopready,
  output logic        nextrowbotready,
  output logic        lastcolumn,
  input  logic        nextcolumn,
  input  logic        nextrowtop,
  input  logic        nextrowbot,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy
`ifdef BITMAP_SLICER_WDOG_EN
  , output logic      wdog_err
`endif
);

  state_t      state;
  logic [5:0]  wptr;
  logic [23:0] rows [BMP_ROWS];

  logic [4:0]  col_idx;
  logic [5:0]  top_idx;
  logic [5:0]  bot_idx;
  logic        col_strobe, top_strobe, bot_strobe;
  logic        col_exh, top_exh, bot_exh;
  logic        go;
  logic        all_done;
  logic        last_col;

  logic [63:0] col_mux;
  logic [4:0]  col_bit;
  logic [63:0] col_hold;
  logic [23:0] top_hold;
  logic [23:0] bot_hold;

`ifdef BITMAP_SLICER_WDOG_EN
  localparam int unsigned WDOG_W = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WDOG_W-1:0] wdog_cnt;
`endif

  assign go       = (state == START);
  assign all_done = col_exh & top_exh & bot_exh;

  slice_stream_ctl #(
    .IDX_W    (5),
    .FIRST_IDX(0),
    .LAST_IDX (BMP_COLS - 1),
    .DESCEND  (1'b0),
    .ACK_BLANK(ACK_BLANK)
  ) u_col_ctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .ack      (nextcolumn),
    .idx      (col_idx),
    .strobe   (col_strobe),
    .exhausted(col_exh)
  );

  slice_stream_ctl #(
    .IDX_W    (6),
    .FIRST_IDX(0),
    .LAST_IDX (HALF_ROWS - 1),
    .DESCEND  (1'b0),
    .ACK_BLANK(ACK_BLANK)
  ) u_top_ctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .ack      (nextrowtop),
    .idx      (top_idx),
    .strobe   (top_strobe),
    .exhausted(top_exh)
  );

  slice_stream_ctl #(
    .IDX_W    (6),
    .FIRST_IDX(BMP_ROWS - 1),
    .LAST_IDX (HALF_ROWS),
    .DESCEND  (1'b1),
    .ACK_BLANK(ACK_BLANK)
  ) u_bot_ctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .ack      (nextrowbot),
    .idx      (bot_idx),
    .strobe   (bot_strobe),
    .exhausted(bot_exh)
  );

  always_ff @(posedge clk) begin
    if (state == LOAD && load_valid) begin
      rows[wptr] <= load_data;
    end
  end

  // Bit 23 of a row is the leftmost pixel, so column c reads bit 23-c of every row.
  assign col_bit = 5'(BMP_COLS - 1) - col_idx;

  always_comb begin
    col_mux = '0;
    for (int unsigned r = 0; r < BMP_ROWS; r++) begin
      col_mux[r] = rows[r][col_bit];
    end
  end

  // Data is taken straight from the buffer during the strobe and held afterwards,
  // so outputs read zero out of reset even though the buffer itself is not cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_hold <= '0;
      top_hold <= '0;
      bot_hold <= '0;
    end else begin
      if (col_strobe) col_hold <= col_mux;
      if (top_strobe) top_hold <= rows[top_idx];
      if (bot_strobe) bot_hold <= rows[bot_idx];
    end
  end

  always_comb begin
    bitcolumn = col_strobe ? col_mux        : col_hold;
    bitrowtop = top_strobe ? rows[top_idx]  : top_hold;
    bitrowbot = bot_strobe ? rows[bot_idx]  : bot_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      wptr         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        LOAD: begin
          if (load_valid) begin
            wptr <= wptr + 6'd1;
            if (wptr == 6'(BMP_ROWS - 1)) state <= START;
          end
        end
        START: state <= STREAM;
        STREAM: begin
          if (all_done) state <= WAITDONE;
        end
        WAITDONE: begin
          if (alu_done) begin
            result       <= alu_result;
            result_valid <= 1'b1;
            state        <= LOAD;
          end
`ifdef BITMAP_SLICER_WDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            result       <= '1;
            result_valid <= 1'b1;
            state        <= LOAD;
          end
`endif
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_col <= 1'b0;
    end else if (state != STREAM) begin
      last_col <= 1'b0;
    end else if (col_strobe && col_idx == 5'(BMP_COLS - 1)) begin
      last_col <= 1'b1;
    end
  end

`ifdef BITMAP_SLICER_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state != WAITDONE) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
        if (!alu_done && wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) wdog_err <= 1'b1;
      end
    end
  end
`endif

  assign lastcolumn      = (state == STREAM) &&
                           (last_col || (col_strobe && col_idx == 5'(BMP_COLS - 1)));
  assign load_ready      = (state == LOAD);
  assign start           = (state == START);
  assign busy            = (state != LOAD);
  assign nextcolumnready = col_strobe;
  assign nextrowtopready = top_strobe;
  assign nextrowbotready = bot_strobe;

endmodule

// File: tb/tb_bitmap_slicer.sv
// Directed bench for bitmap_slicer; exercises the watchdog when BITMAP_SLICER_WDOG_EN is defined.
module tb_bitmap_slicer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [23:0] load_data;
  logic        load_ready;
  logic        start;
  logic [63:0] bitcolumn;
  logic [23:0] bitrowtop;
  logic [23:0] bitrowbot;
  logic        nextcolumnready, nextrowtopready, nextrowbotready;
  logic        lastcolumn;
  logic        nextcolumn, nextrowtop, nextrowbot;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
`ifdef BITMAP_SLICER_WDOG_EN
  logic        wdog_err;
`endif

  always #5 clk = ~clk;

  bitmap_slicer #(
    .ACK_BLANK(1)
`ifdef BITMAP_SLICER_WDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .start          (start),
    .bitcolumn      (bitcolumn),
    .bitrowtop      (bitrowtop),
    .bitrowbot      (bitrowbot),
    .nextcolumnready(nextcolumnready),
    .nextrowtopready(nextrowtopready),
    .nextrowbotready(nextrowbotready),
    .lastcolumn     (lastcolumn),
    .nextcolumn     (nextcolumn),
    .nextrowtop     (nextrowtop),
    .nextrowbot     (nextrowbot),
    .alu_done       (alu_done),
    .alu_result     (alu_result),
    .result         (result),
    .result_valid   (result_valid),
    .busy           (busy)
`ifdef BITMAP_SLICER_WDOG_EN
    , .wdog_err     (wdog_err)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [23:0] bmp [64];
  logic [63:0] col_data [24];
  logic [23:0] top_data [32];
  logic [23:0] bot_data [32];

  int unsigned cyc = 0;
  int unsigned col_cnt, top_cnt, bot_cnt, start_cnt, rv_cnt;
  int unsigned col_gap_err, top_gap_err, bot_gap_err, lc_early, lc_hold_err;
  int unsigned start_cyc, first_top_cyc, last_bot_cyc, col_last, top_last, bot_last;
  int unsigned wdog_cyc;
  logic        lc_at23, wdog_seen;
  logic        ack_held = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    col_cnt = 0; top_cnt = 0; bot_cnt = 0; start_cnt = 0; rv_cnt = 0;
    col_gap_err = 0; top_gap_err = 0; bot_gap_err = 0; lc_early = 0; lc_hold_err = 0;
    start_cyc = 0; first_top_cyc = 0; last_bot_cyc = 0; col_last = 0; top_last = 0; bot_last = 0;
    wdog_cyc = 0; lc_at23 = 1'b0; wdog_seen = 1'b0;
    for (int i = 0; i < 24; i++) col_data[i] = '1;
    for (int i = 0; i < 32; i++) begin top_data[i] = '1; bot_data[i] = '1; end
  endtask

  task automatic load_bitmap();
    for (int r = 0; r < 64; r++) begin
      load_valid = 1'b1;
      load_data  = bmp[r];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  task automatic wait_streams(input int unsigned bound);
    int unsigned n = 0;
    while (!(col_cnt == 24 && top_cnt == 32 && bot_cnt == 32) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("streams_done", 64'(col_cnt == 24 && top_cnt == 32 && bot_cnt == 32), 64'd1);
  endtask

  task automatic check_counts();
    check_eq("col_strobes", 64'(col_cnt), 64'd24);
    check_eq("top_strobes", 64'(top_cnt), 64'd32);
    check_eq("bot_strobes", 64'(bot_cnt), 64'd32);
    check_eq("lastcol_at23", 64'(lc_at23), 64'd1);
    check_eq("lastcol_early", 64'(lc_early), 64'd0);
    check_eq("lastcol_hold", 64'(lc_hold_err), 64'd0);
    check_eq("stream_gaps", 64'(col_gap_err + top_gap_err + bot_gap_err), 64'd0);
  endtask

  task automatic check_model_data();
    logic [63:0] exp_col;
    for (int c = 0; c < 24; c++) begin
      exp_col = '0;
      for (int r = 0; r < 64; r++) exp_col[r] = bmp[r][23-c];
      check_eq($sformatf("col%0d", c), col_data[c], exp_col);
    end
    for (int k = 0; k < 32; k++) begin
      check_eq($sformatf("top%0d", k), 64'(top_data[k]), 64'(bmp[k]));
      check_eq($sformatf("bot%0d", k), 64'(bot_data[k]), 64'(bmp[63-k]));
    end
  endtask

  task automatic finish_alu(input logic [15:0] word);
    repeat (3) @(posedge clk);
    #1;
    check_eq("busy_waitdone", 64'(busy), 64'd1);
    alu_result = word;
    alu_done   = 1'b1;
    @(posedge clk); #1;
    alu_done   = 1'b0;
    check_eq("result", 64'(result), 64'(word));
    check_eq("load_ready_after", 64'(load_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("result_valid_pulses", 64'(rv_cnt), 64'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Ack generator: either held high, or returned two cycles after each strobe.
  initial begin
    logic c1, c2, t1, t2, b1, b2;
    c1 = 0; c2 = 0; t1 = 0; t2 = 0; b1 = 0; b2 = 0;
    nextcolumn = 1'b0; nextrowtop = 1'b0; nextrowbot = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_held) begin
        nextcolumn = 1'b1; nextrowtop = 1'b1; nextrowbot = 1'b1;
      end else begin
        nextcolumn = c2; nextrowtop = t2; nextrowbot = b2;
      end
      c2 = c1; c1 = nextcolumnready;
      t2 = t1; t1 = nextrowtopready;
      b2 = b1; b1 = nextrowbotready;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (start) begin start_cnt++; start_cyc = cyc; end
      if (result_valid) rv_cnt++;
      if (lastcolumn && !(col_cnt == 24 || (nextcolumnready && col_cnt == 23))) lc_early++;
      if (col_cnt == 24 && top_cnt < 32 && busy && !lastcolumn) lc_hold_err++;
      if (nextcolumnready) begin
        if (col_cnt == 23) lc_at23 = lastcolumn;
        if (col_cnt < 24) col_data[col_cnt] = bitcolumn;
        if (col_cnt > 0 && cyc - col_last != 3) col_gap_err++;
        col_last = cyc;
        col_cnt++;
      end
      if (nextrowtopready) begin
        if (top_cnt == 0) first_top_cyc = cyc;
        if (top_cnt < 32) top_data[top_cnt] = bitrowtop;
        if (top_cnt > 0 && cyc - top_last != 3) top_gap_err++;
        top_last = cyc;
        top_cnt++;
      end
      if (nextrowbotready) begin
        if (bot_cnt < 32) bot_data[bot_cnt] = bitrowbot;
        if (bot_cnt > 0 && cyc - bot_last != 3) bot_gap_err++;
        bot_last = cyc;
        last_bot_cyc = cyc;
        bot_cnt++;
      end
`ifdef BITMAP_SLICER_WDOG_EN
      if (wdog_err && !wdog_seen) begin wdog_seen = 1'b1; wdog_cyc = cyc; end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; alu_done = 1'b0; alu_result = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_load_ready", 64'(load_ready), 64'd1);
    check_eq("rst_outputs", {start, busy, nextcolumnready, nextrowtopready, nextrowbotready,
                             lastcolumn, result_valid}, 64'd0);
    check_eq("rst_data", bitcolumn | 64'(bitrowtop) | 64'(bitrowbot) | 64'(result), 64'd0);
`ifdef BITMAP_SLICER_WDOG_EN
    check_eq("rst_wdog", 64'(wdog_err), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 1: all-zero bitmap, delayed ack, early alu_done ignored.
    for (int r = 0; r < 64; r++) bmp[r] = '0;
    clear_stats();
    load_bitmap();
    check_eq("start_pulse", 64'(start), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    alu_result = 16'hDEAD; alu_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    alu_done = 1'b0;
    wait_streams(400);
    check_counts();
    check_eq("zero_data", 64'(col_data[0] | col_data[12] | col_data[23]) |
                          64'(top_data[0] | top_data[31] | bot_data[0] | bot_data[31]), 64'd0);
    check_eq("early_done_result", 64'(result), 64'd0);
    check_eq("early_done_rv", 64'(rv_cnt), 64'd0);
    finish_alu(16'h1A38);

    // Run 2: single pixels, ack held high, load_valid held during streaming.
    for (int r = 0; r < 64; r++) bmp[r] = '0;
    bmp[5]  = 24'h100000;
    bmp[40] = 24'h000001;
    clear_stats();
    ack_held = 1'b1;
    load_bitmap();
    load_valid = 1'b1;
    load_data  = 24'hFFFFFF;
    wait_streams(400);
    load_valid = 1'b0;
    load_data  = '0;
    check_counts();
    check_eq("pix_col3", col_data[3], 64'h20);
    check_eq("pix_col0", col_data[0], 64'h0);
    check_eq("pix_col4", col_data[4], 64'h0);
    check_eq("pix_col23", col_data[23], 64'h0000_0100_0000_0000);
    check_eq("pix_top5", 64'(top_data[5]), 64'h100000);
    check_eq("pix_top4", 64'(top_data[4]), 64'h0);
    check_eq("pix_bot23", 64'(bot_data[23]), 64'h000001);
    check_eq("pix_bot0", 64'(bot_data[0]), 64'h0);
    check_eq("first_strobe_lat", 64'(first_top_cyc - start_cyc), 64'd1);
    check_eq("last_strobe_lat", 64'(last_bot_cyc - start_cyc), 64'd94);
    ack_held = 1'b0;
    finish_alu(16'h0421);

    // Run 3: dense pattern, full data check against the bench's bitmap.
    for (int r = 0; r < 64; r++) bmp[r] = 24'h5A3C96 ^ (24'(r) * 24'h010203);
    clear_stats();
    load_bitmap();
    wait_streams(400);
    check_counts();
    check_model_data();
    finish_alu(16'h1F5B);

    // Run 4: reset in the middle of streaming, then a fresh load.
    clear_stats();
    load_bitmap();
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_strobes", {nextcolumnready, nextrowtopready, nextrowbotready}, 64'd0);
    check_eq("midrst_load_ready", 64'(load_ready), 64'd1);
    check_eq("midrst_busy_start", {busy, start, lastcolumn}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_no_rv", 64'(rv_cnt), 64'd0);
    check_eq("midrst_no_start", 64'(start_cnt), 64'd1);
    for (int r = 0; r < 64; r++) bmp[r] = ~(24'h5A3C96 ^ (24'(r) * 24'h000107));
    clear_stats();
    load_bitmap();
    @(negedge clk);
    check_eq("reload_start", 64'(start_cnt), 64'd1);
    wait_streams(400);
    check_counts();
    check_model_data();
    finish_alu(16'h7E01);

`ifdef BITMAP_SLICER_WDOG_EN
    // Run 5: alu_done never arrives.
    for (int r = 0; r < 64; r++) bmp[r] = '0;
    clear_stats();
    load_bitmap();
    wait_streams(400);
    for (int n = 0; n < 60 && !wdog_seen; n++) begin
      @(posedge clk); #1;
    end
    check_eq("wdog_fired", 64'(wdog_seen), 64'd1);
    check_eq("wdog_latency", 64'(wdog_cyc - last_bot_cyc), 64'd20);
    check_eq("wdog_result", 64'(result), 64'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    check_eq("wdog_rv", 64'(rv_cnt), 64'd1);
    check_eq("wdog_sticky", {wdog_err, load_ready}, 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitmap_slicer.md
Name: bitmap_slicer

Overview:
- Producer side of the compare-ALU slice interface.
- Buffers one 64-row x 24-column bitmap loaded row by row, then streams it to cmpalu:
  - columns, left to right, 64 bits each;
  - top rows, downward from row 0, 24 bits each;
  - bottom rows, upward from row 63, 24 bits each.
- Each of the three streams has its own handshake.
- Captures the 16-bit shift/scale word from cmpalu when it finishes and hands it upstream.

Parameters:
- ACK_BLANK, 1: cycles after a ready strobe during which the matching ack input is ignored.
- WDOG_CYCLES, 255: cycles allowed in WAITDONE before the watchdog fires (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- load_valid  in  1  load_data holds a valid bitmap row.
- load_data  in  24  bitmap row. Bit 23 = leftmost pixel.
- load_ready  out  1  slicer accepts a row this cycle.
- start  out  1  one-cycle pulse that resets cmpalu.
- bitcolumn  out  64  current column. Bit r = pixel of row r.
- bitrowtop  out  24  current top-stream row.
- bitrowbot  out  24  current bottom-stream row.
- nextcolumnready  out  1  one-cycle strobe: bitcolumn is new.
- nextrowtopready  out  1  one-cycle strobe: bitrowtop is new.
- nextrowbotready  out  1  one-cycle strobe: bitrowbot is new.
- lastcolumn  out  1  level: current column is column 23.
- nextcolumn  in  1  consumer ack: column checked.
- nextrowtop  in  1  consumer ack: top row checked.
- nextrowbot  in  1  consumer ack: bottom row checked.
- alu_done  in  1  cmpalu finished.
- alu_result  in  16  cmpalu result word.
- result  out  16  captured result.
- result_valid  out  1  one-cycle pulse when result is updated.
- busy  out  1  high in any state other than LOAD.

Behaviour:
- Reset (rst_n low): all outputs 0 except load_ready=1. State LOAD. All indices and result cleared. Row buffer contents are don't-care.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1 writes load_data to row[wptr] and increments wptr (6-bit).
  - The write at wptr=63 wraps wptr to 0 and moves to START.
- START: start=1 for exactly one cycle; load_ready=0; then STREAM.
- STREAM: three independent stream controllers run concurrently.
  - Column stream: index 0..23. bitcolumn[r] = row[r][23-c].
  - Top stream: rows 0..31 in order.
  - Bottom stream: rows 63..32 in order.
  - Each controller cycles through three phases:
    - PRESENT: drive data and strobe high for 1 cycle.
    - BLANK: wait ACK_BLANK cycles; ack ignored.
    - WAIT: wait for ack=1. If the index is not final, advance and return to PRESENT. If final, the stream is exhausted.
  - Data outputs hold stable from PRESENT until the next PRESENT.
  - lastcolumn rises together with the column-23 strobe and holds until STREAM is left.
- Transition to WAITDONE: when all three streams are exhausted.
- WAITDONE: on alu_done=1, capture alu_result into result, pulse result_valid for 1 cycle, then go to LOAD.
- Early alu_done: if alu_done is high before all streams are exhausted, it is ignored. Streams always run to completion.
- Loads while not in LOAD: load_valid is ignored (load_ready=0). No row is written.
- Reset mid-operation: aborts immediately. No result_valid. start is not re-issued until the next full load completes.
- Overlaps: strobe and ack of different streams may coincide; streams do not interact.
- Latency: minimum total from START is 1 + 32*(2+ACK_BLANK) cycles (top and bottom run in parallel), plus the alu_done wait.

Optional Feature:
- Macro: BITMAP_SLICER_WDOG_EN.
- Defined:
  - Adds output wdog_err (1 bit, reset 0) and an 8-bit+ counter that clears on entry to WAITDONE.
  - If WDOG_CYCLES cycles elapse in WAITDONE without alu_done: set wdog_err=1 (sticky until rst_n), force result=16'hFFFF, pulse result_valid, go to LOAD.
- Undefined: no port and no counter. WAITDONE waits indefinitely.

Decomposition:
- Package cmp_slice_pkg holds:
  - BMP_ROWS=64, BMP_COLS=24, HALF_ROWS=32;
  - state enum LOAD/START/STREAM/WAITDONE;
  - result field localparams: LSHIFT [4:0], DSHIFT [10:5], HSCALE bit 11, VSCALE bit 12.
- Sub-module slice_stream_ctl (parameters: LAST_IDX, ACK_BLANK; index direction set by a parameter):
  - inputs: go, ack;
  - outputs: idx, strobe, exhausted;
  - instanced three times.
- Top level holds: row buffer, column transpose mux, load FSM, result capture.

Test Plan:
- All-zero bitmap, ack returned 2 cycles after each strobe, alu_done asserted later with alu_result=16'h1A38 -> exactly 24 column, 32 top and 32 bottom strobes; lastcolumn high from the column-23 strobe on; result=16'h1A38 with a single result_valid pulse.
- Single pixel at row 5, column 3 (load_data=24'h100000 on row 5) -> bitcolumn=64'h20 at column index 3 and 0 at all other columns; bitrowtop=24'h100000 at top index 5.
- Ack held high continuously -> each stream advances every 2+ACK_BLANK cycles; no duplicate or skipped indices.
- load_valid held high during STREAM -> buffer unchanged (verify the column values).
- rst_n pulsed low mid-STREAM -> all strobes stop that cycle; load_ready=1; no result_valid; a fresh 64-row load restarts with a start pulse.
- BITMAP_SLICER_WDOG_EN defined with WDOG_CYCLES=16, alu_done never asserted -> wdog_err=1 and result=16'hFFFF 16 cycles after entering WAITDONE.
